// File: rtl/sys_reg_scanner.sv
// Register-file scanner: sweeps the CPU debug read address over a range and
// queues {address, value} captures in a show-ahead FIFO.
module sys_reg_scanner #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1
) (
  input  logic                         SYS_clk,
  input  logic                         SYS_reset,
  input  logic                         SCAN_start,
  input  logic                         SCAN_stop,
  input  logic [1:0]                   SCAN_mode,
  input  logic [ADDR_W-1:0]            SCAN_first,
  input  logic [ADDR_W-1:0]            SCAN_last,
  output logic [ADDR_W-1:0]            SCAN_reg_addr,
  input  logic [DATA_W-1:0]            SCAN_reg_val,
  input  logic                         SCAN_rd_en,
  output logic [ADDR_W+DATA_W-1:0]     SCAN_rd_data,
  output logic                         SCAN_rd_valid,
  output logic                         SCAN_busy,
  output logic                         SCAN_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   SCAN_count
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_CHANGE = 2'b10;

  logic [0:0]        state;
  logic [ADDR_W-1:0] first_q;
  logic [ADDR_W-1:0] last_q;
  logic [1:0]        mode_q;
  logic [1:0]        mode_in;
  logic [LAT_W-1:0]  lat_cnt;

  logic [DATA_W-1:0] shadow [NREG];
  logic [NREG-1:0]   shadow_vld;

  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [ENT_W-1:0]  head_next;

  logic start_ok, capture, at_last, changed;
  logic push_req, push_ok, pop_ok, full, drop;
  logic [ENT_W-1:0] push_data;

  // A stop in the same cycle as a start wins; otherwise start (re)launches.
  assign start_ok  = SCAN_start && !((state == ST_SCAN) && SCAN_stop);
  // A restart abandons the capture that would have landed on its edge.
  assign capture   = (state == ST_SCAN) && !start_ok && (lat_cnt == '0);
  assign at_last   = (SCAN_reg_addr == last_q);
  assign changed   = !shadow_vld[SCAN_reg_addr] || (shadow[SCAN_reg_addr] != SCAN_reg_val);
  assign push_req  = capture && ((mode_q != MODE_CHANGE) || changed);
  assign push_data = {SCAN_reg_addr, SCAN_reg_val};

  assign full    = (SCAN_count == FULL_CNT);
  assign pop_ok  = SCAN_rd_en && (SCAN_count != '0);
  assign push_ok = push_req && (!full || pop_ok);
  assign drop    = push_req && full && !pop_ok;

  assign mode_in    = (SCAN_mode == 2'b11) ? MODE_SINGLE : SCAN_mode;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  assign SCAN_busy     = (state == ST_SCAN);
  assign SCAN_rd_valid = (SCAN_count != '0);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state         <= ST_IDLE;
      SCAN_reg_addr <= '0;
      lat_cnt       <= '0;
      first_q       <= '0;
      last_q        <= '0;
      mode_q        <= MODE_SINGLE;
    end else if (start_ok) begin
      state         <= ST_SCAN;
      SCAN_reg_addr <= SCAN_first;
      first_q       <= SCAN_first;
      last_q        <= SCAN_last;
      mode_q        <= mode_in;
      lat_cnt       <= LAT_RELOAD;
    end else if (state == ST_SCAN) begin
      if (capture) begin
        lat_cnt <= LAT_RELOAD;
        if (!at_last)
          SCAN_reg_addr <= SCAN_reg_addr + ADDR_W'(1);
        else if (mode_q == MODE_SINGLE)
          state <= ST_IDLE;
        else
          SCAN_reg_addr <= first_q;
      end else begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (SCAN_stop)
        state <= ST_IDLE;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)
      shadow_vld <= '0;
    else if (start_ok)
      shadow_vld <= '0;
    else if (capture)
      shadow_vld[SCAN_reg_addr] <= 1'b1;
  end

  // NOTE: storage arrays are not reset; their valid bits and pointers are,
  // so stale contents are never observed.
  always_ff @(posedge SYS_clk) begin
    if (capture)
      shadow[SCAN_reg_addr] <= SCAN_reg_val;
  end

  always_ff @(posedge SYS_clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= push_data;
  end

  // NOTE: head_next gets a default before any branch so no latch is inferred.
  always_comb begin
    head_next = SCAN_rd_data;
    if (SCAN_count == '0) begin
      if (push_ok)
        head_next = push_data;
    end else if (pop_ok) begin
      if (SCAN_count == CNT_W'(1)) begin
        if (push_ok)
          head_next = push_data;
      end else begin
        head_next = fifo_mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      SCAN_count    <= '0;
      SCAN_overflow <= 1'b0;
      SCAN_rd_data  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr_nxt;
      if (push_ok && !pop_ok)
        SCAN_count <= SCAN_count + CNT_W'(1);
      else if (pop_ok && !push_ok)
        SCAN_count <= SCAN_count - CNT_W'(1);
      if (start_ok)
        SCAN_overflow <= 1'b0;
      else if (drop)
        SCAN_overflow <= 1'b1;
      SCAN_rd_data <= head_next;
    end
  end

endmodule

// File: tb/tb_sys_reg_scanner.sv
// Directed bench for sys_reg_scanner: one instance with READ_LAT=1/DEPTH=16,
// one with READ_LAT=2/DEPTH=4, sharing control inputs and a register model.
module tb_sys_reg_scanner;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = AW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] first = '0;
  logic [AW-1:0] last = '0;
  logic          rd_en = 1'b0;

  logic [DW-1:0] regs [32];

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_val, b_val;
  logic [EW-1:0] a_data, b_data;
  logic          a_valid, b_valid, a_busy, b_busy, a_ovf, b_ovf;
  logic [4:0]    a_count;
  logic [2:0]    b_count;

  assign a_val = regs[a_addr];
  assign b_val = regs[b_addr];

  int errors = 0;
  int checks = 0;

  sys_reg_scanner #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .READ_LAT(1)) dut_a (
    .SYS_clk(clk), .SYS_reset(rst), .SCAN_start(start), .SCAN_stop(stop),
    .SCAN_mode(mode), .SCAN_first(first), .SCAN_last(last),
    .SCAN_reg_addr(a_addr), .SCAN_reg_val(a_val), .SCAN_rd_en(rd_en),
    .SCAN_rd_data(a_data), .SCAN_rd_valid(a_valid), .SCAN_busy(a_busy),
    .SCAN_overflow(a_ovf), .SCAN_count(a_count)
  );

  sys_reg_scanner #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .READ_LAT(2)) dut_b (
    .SYS_clk(clk), .SYS_reset(rst), .SCAN_start(start), .SCAN_stop(stop),
    .SCAN_mode(mode), .SCAN_first(first), .SCAN_last(last),
    .SCAN_reg_addr(b_addr), .SCAN_reg_val(b_val), .SCAN_rd_en(rd_en),
    .SCAN_rd_data(b_data), .SCAN_rd_valid(b_valid), .SCAN_busy(b_busy),
    .SCAN_overflow(b_ovf), .SCAN_count(b_count)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    start = 1'b0; stop = 1'b0; rd_en = 1'b0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Returns at the negedge just after the start edge E.
  task automatic launch(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic [1:0] m);
    first = f; last = l; mode = m; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (a_addr !== 5'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", a_addr); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", a_valid); end
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", a_count); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", a_ovf); end
    checks++; if (a_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", a_data); end
    checks++; if (b_busy !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL rst_b: busy %b count %0d want 0 0", b_busy, b_count); end
  endtask

  task automatic test_single_shot;
    logic [EW-1:0] exp;
    do_reset();
    regs[8] = 32'h11; regs[9] = 32'h22; regs[10] = 32'h33;
    launch(5'd8, 5'd10, 2'b00);
    checks++; if (a_busy !== 1'b1 || a_addr !== 5'd8) begin errors++; $display("FAIL ss_start: busy %b addr %0d want 1 8", a_busy, a_addr); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL ss_valid0: got %b want 0", a_valid); end
    tick(1);
    checks++; if (a_valid !== 1'b1 || a_count !== 5'd1 || a_addr !== 5'd9) begin errors++; $display("FAIL ss_cap1: valid %b count %0d addr %0d want 1 1 9", a_valid, a_count, a_addr); end
    tick(2);
    checks++; if (a_busy !== 1'b0 || a_count !== 5'd3 || a_addr !== 5'd10) begin errors++; $display("FAIL ss_done: busy %b count %0d addr %0d want 0 3 10", a_busy, a_count, a_addr); end
    for (int i = 0; i < 3; i++) begin
      exp = {AW'(8 + i), regs[8 + i]};
      checks++; if (a_valid !== 1'b1 || a_data !== exp) begin errors++; $display("FAIL ss_pop%0d: valid %b data %h want 1 %h", i, a_valid, a_data, exp); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
    end
    checks++; if (a_valid !== 1'b0 || a_count !== 5'd0) begin errors++; $display("FAIL ss_empty: valid %b count %0d want 0 0", a_valid, a_count); end
  endtask

  task automatic test_single_reg_mode3;
    do_reset();
    regs[5] = 32'h5555_0005;
    launch(5'd5, 5'd5, 2'b11);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL m3_busy: got %b want 1", a_busy); end
    tick(1);
    checks++; if (a_busy !== 1'b0 || a_count !== 5'd1 || a_addr !== 5'd5) begin errors++; $display("FAIL m3_done: busy %b count %0d addr %0d want 0 1 5", a_busy, a_count, a_addr); end
    checks++; if (a_data !== {5'd5, 32'h5555_0005}) begin errors++; $display("FAIL m3_data: got %h want %h", a_data, {5'd5, 32'h5555_0005}); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] wl [4];
    logic [EW-1:0] exp;
    wl = '{5'd30, 5'd31, 5'd0, 5'd1};
    do_reset();
    regs[30] = 32'h3030; regs[31] = 32'h3131; regs[0] = 32'h0A0A; regs[1] = 32'h0101;
    launch(5'd30, 5'd1, 2'b00);
    checks++; if (b_busy !== 1'b1 || b_addr !== 5'd30) begin errors++; $display("FAIL wr_start: busy %b addr %0d want 1 30", b_busy, b_addr); end
    tick(1);
    checks++; if (b_addr !== 5'd30 || b_count !== 3'd0) begin errors++; $display("FAIL wr_hold: addr %0d count %0d want 30 0", b_addr, b_count); end
    tick(1);
    checks++; if (b_addr !== 5'd31 || b_count !== 3'd1) begin errors++; $display("FAIL wr_cap1: addr %0d count %0d want 31 1", b_addr, b_count); end
    tick(5);
    checks++; if (b_busy !== 1'b1 || b_count !== 3'd3 || b_addr !== 5'd1) begin errors++; $display("FAIL wr_k7: busy %b count %0d addr %0d want 1 3 1", b_busy, b_count, b_addr); end
    tick(1);
    checks++; if (b_busy !== 1'b0 || b_count !== 3'd4) begin errors++; $display("FAIL wr_done: busy %b count %0d want 0 4", b_busy, b_count); end
    for (int i = 0; i < 4; i++) begin
      exp = {wl[i], regs[wl[i]]};
      checks++; if (b_data !== exp) begin errors++; $display("FAIL wr_pop%0d: got %h want %h", i, b_data, exp); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
    end
  endtask

  task automatic test_change_only;
    logic [AW-1:0] al [5];
    logic [DW-1:0] vl [5];
    logic [EW-1:0] exp;
    al = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd2};
    vl = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hDEAD};
    do_reset();
    for (int i = 0; i < 4; i++) regs[i] = vl[i];
    launch(5'd0, 5'd3, 2'b10);
    tick(12);
    checks++; if (a_count !== 5'd4 || a_busy !== 1'b1) begin errors++; $display("FAIL co_3sweeps: count %0d busy %b want 4 1", a_count, a_busy); end
    regs[2] = 32'hDEAD;
    tick(8);
    checks++; if (a_count !== 5'd5) begin errors++; $display("FAIL co_change: count %0d want 5", a_count); end
    stop = 1'b1; tick(1); stop = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_count !== 5'd5) begin errors++; $display("FAIL co_stop: busy %b count %0d want 0 5", a_busy, a_count); end
    for (int i = 0; i < 5; i++) begin
      exp = {al[i], vl[i]};
      checks++; if (a_data !== exp) begin errors++; $display("FAIL co_pop%0d: got %h want %h", i, a_data, exp); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
    end
  endtask

  task automatic test_overflow;
    logic [AW-1:0] al [4];
    logic [EW-1:0] exp;
    al = '{5'd1, 5'd2, 5'd3, 5'd5};
    do_reset();
    for (int i = 0; i < 8; i++) regs[i] = 32'h100 + i;
    launch(5'd0, 5'd7, 2'b01);
    tick(9);
    checks++; if (b_count !== 3'd4 || b_ovf !== 1'b0) begin errors++; $display("FAIL ov_full: count %0d ovf %b want 4 0", b_count, b_ovf); end
    tick(1);
    checks++; if (b_count !== 3'd4 || b_ovf !== 1'b1) begin errors++; $display("FAIL ov_drop: count %0d ovf %b want 4 1", b_count, b_ovf); end
    tick(1);
    checks++; if (b_data !== {5'd0, 32'h100}) begin errors++; $display("FAIL ov_head0: got %h want %h", b_data, {5'd0, 32'h100}); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    checks++; if (b_count !== 3'd4 || b_ovf !== 1'b1) begin errors++; $display("FAIL ov_pushpop: count %0d ovf %b want 4 1", b_count, b_ovf); end
    checks++; if (b_data !== {5'd1, 32'h101}) begin errors++; $display("FAIL ov_head1: got %h want %h", b_data, {5'd1, 32'h101}); end
    stop = 1'b1; tick(1); stop = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL ov_stop: busy %b want 0", b_busy); end
    for (int i = 0; i < 4; i++) begin
      exp = {al[i], 32'h100 + 32'(al[i])};
      checks++; if (b_data !== exp) begin errors++; $display("FAIL ov_pop%0d: got %h want %h", i, b_data, exp); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
    end
    checks++; if (b_count !== 3'd0 || b_valid !== 1'b0) begin errors++; $display("FAIL ov_empty: count %0d valid %b want 0 0", b_count, b_valid); end
  endtask

  task automatic test_stop_restart;
    do_reset();
    for (int i = 0; i < 8; i++) regs[16 + i] = 32'h1600 + i;
    launch(5'd16, 5'd23, 2'b01);
    tick(2);
    checks++; if (a_count !== 5'd2) begin errors++; $display("FAIL sr_pre: count %0d want 2", a_count); end
    stop = 1'b1; tick(1); stop = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_count !== 5'd3) begin errors++; $display("FAIL sr_stop: busy %b count %0d want 0 3", a_busy, a_count); end
    launch(5'd16, 5'd23, 2'b01);
    checks++; if (a_busy !== 1'b1 || a_addr !== 5'd16 || a_count !== 5'd3) begin errors++; $display("FAIL sr_start2: busy %b addr %0d count %0d want 1 16 3", a_busy, a_addr, a_count); end
    tick(13);
    checks++; if (a_count !== 5'd16 || a_ovf !== 1'b0) begin errors++; $display("FAIL sr_full: count %0d ovf %b want 16 0", a_count, a_ovf); end
    tick(1);
    checks++; if (a_count !== 5'd16 || a_ovf !== 1'b1) begin errors++; $display("FAIL sr_ovf: count %0d ovf %b want 16 1", a_count, a_ovf); end
    launch(5'd4, 5'd23, 2'b01);
    checks++; if (a_busy !== 1'b1 || a_addr !== 5'd4) begin errors++; $display("FAIL sr_restart: busy %b addr %0d want 1 4", a_busy, a_addr); end
    checks++; if (a_ovf !== 1'b0 || a_count !== 5'd16) begin errors++; $display("FAIL sr_kept: ovf %b count %0d want 0 16", a_ovf, a_count); end
    checks++; if (a_data !== {5'd16, 32'h1600}) begin errors++; $display("FAIL sr_head: got %h want %h", a_data, {5'd16, 32'h1600}); end
  endtask

  task automatic test_reset_mid_scan;
    do_reset();
    launch(5'd0, 5'd31, 2'b01);
    tick(3);
    checks++; if (a_count !== 5'd3 || a_data === '0) begin errors++; $display("FAIL rm_pre: count %0d data %h want 3 nonzero", a_count, a_data); end
    rst = 1'b1; tick(1);
    checks++; if (a_addr !== 5'd0 || a_busy !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL rm_ctl: addr %0d busy %b valid %b want 0 0 0", a_addr, a_busy, a_valid); end
    checks++; if (a_count !== 5'd0 || a_ovf !== 1'b0 || a_data !== '0) begin errors++; $display("FAIL rm_fifo: count %0d ovf %b data %h want 0 0 0", a_count, a_ovf, a_data); end
    rst = 1'b0; tick(1);
    checks++; if (a_busy !== 1'b0 || a_count !== 5'd0) begin errors++; $display("FAIL rm_after: busy %b count %0d want 0 0", a_busy, a_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * (i + 1);
    test_reset();
    test_single_shot();
    test_single_reg_mode3();
    test_wrap();
    test_change_only();
    test_overflow();
    test_stop_restart();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
